// File: rtl/cpu_mu0_param.sv
// cpu_mu0_param: parametrised MU0 accumulator CPU.
//   DATA_WIDTH-bit accumulator and words, 4-bit opcode in the top nibble,
//   DATA_WIDTH-4 bit operand/address. Memory reads have a fixed latency of
//   READ_LATENCY cycles from the read strobe to the readdata sample cycle.
//   All bus outputs (address/read/write) are registered.
// Optional feature: define CPU_MU0_PERF_COUNT_EN to add the saturating
//   cycle_count and instr_count outputs.
module cpu_mu0_param #(
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-5:0] RESET_PC     = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  running,
  output logic                  fault,
  output logic [DATA_WIDTH-5:0] address,
  output logic                  write,
  output logic                  read,
  output logic [DATA_WIDTH-1:0] writedata,
  input  logic [DATA_WIDTH-1:0] readdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef CPU_MU0_PERF_COUNT_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           instr_count
`endif
);

  localparam int ADDR_WIDTH = DATA_WIDTH - 4;
  // Wait counter runs 0 .. READ_LATENCY-1 inside each *_WAIT state.
  localparam int                WAIT_W    = $clog2(READ_LATENCY + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;
  localparam logic [3:0] OP_OUT = 4'd8;

  typedef enum logic [2:0] {
    FETCH_ADDR,
    FETCH_WAIT,
    EXEC_ADDR,
    EXEC_WAIT,
    EXEC,
    HALTED
  } state_t;

  // Power-up values: the core sits idle in HALTED until the first reset.
  state_t                  state_q     = HALTED;
  logic                    running_q   = 1'b0;
  logic                    fault_q     = 1'b0;
  logic                    out_valid_q = 1'b0;
  logic                    read_q      = 1'b0;
  logic                    write_q     = 1'b0;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   address_q;
  logic [DATA_WIDTH-1:0]   acc_q;
  logic [DATA_WIDTH-1:0]   instr_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [WAIT_W-1:0]       wait_q;

  // Decode / datapath helpers.
  logic                    wait_last;
  logic [3:0]              fetch_op;
  logic [ADDR_WIDTH-1:0]   fetch_opnd;
  logic                    fetch_is_mem;
  logic [3:0]              exec_op;
  logic [ADDR_WIDTH-1:0]   exec_opnd;
  logic                    exec_illegal;
  logic                    take_jump;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic [ADDR_WIDTH-1:0]   pc_d;
  logic [DATA_WIDTH-1:0]   acc_d;

  // Instruction decode: fetch-side decode looks at readdata directly so the
  // next state can be chosen in the same cycle the instruction arrives.
  always_comb begin
    wait_last    = (wait_q == WAIT_LAST);
    fetch_op     = readdata[DATA_WIDTH-1 -: 4];
    fetch_opnd   = readdata[ADDR_WIDTH-1:0];
    fetch_is_mem = (fetch_op == OP_LDA) || (fetch_op == OP_ADD) || (fetch_op == OP_SUB);
    exec_op      = instr_q[DATA_WIDTH-1 -: 4];
    exec_opnd    = instr_q[ADDR_WIDTH-1:0];
    exec_illegal = (exec_op > OP_OUT);
    pc_inc       = pc_q + 1'b1;
  end

  // Branch resolution and accumulator ALU (modulo 2^DATA_WIDTH, no flags).
  always_comb begin
    take_jump = 1'b0;
    acc_d     = acc_q;
    case (exec_op)
      OP_JMP:  take_jump = 1'b1;
      OP_JGE:  take_jump = ~acc_q[DATA_WIDTH-1];
      OP_JNE:  take_jump = (acc_q != '0);
      OP_LDA:  acc_d     = readdata;
      OP_ADD:  acc_d     = acc_q + readdata;
      OP_SUB:  acc_d     = acc_q - readdata;
      default: begin
        take_jump = 1'b0;
        acc_d     = acc_q;
      end
    endcase
    pc_d = take_jump ? exec_opnd : pc_inc;
  end

  // Control FSM: sequences fetch/execute; bus strobes are set on entry to the
  // state in which they must be visible, so every output comes from a flop.
  always_ff @(posedge clk) begin
    read_q      <= 1'b0;
    write_q     <= 1'b0;
    out_valid_q <= 1'b0;
    if (rst) begin
      state_q    <= FETCH_ADDR;
      pc_q       <= RESET_PC;
      acc_q      <= '0;
      instr_q    <= '0;
      wait_q     <= '0;
      running_q  <= 1'b1;
      fault_q    <= 1'b0;
      out_data_q <= '0;
      address_q  <= RESET_PC;
      read_q     <= 1'b1;
    end else begin
      case (state_q)
        FETCH_ADDR: begin
          state_q <= FETCH_WAIT;
          wait_q  <= '0;
        end
        FETCH_WAIT: begin
          if (wait_last) begin
            instr_q <= readdata;
            wait_q  <= '0;
            if (fetch_is_mem) begin
              state_q   <= EXEC_ADDR;
              address_q <= fetch_opnd;
              read_q    <= 1'b1;
            end else begin
              state_q <= EXEC;
              if (fetch_op == OP_STO) begin
                address_q <= fetch_opnd;
                write_q   <= 1'b1;
              end
            end
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        EXEC_ADDR: begin
          state_q <= EXEC_WAIT;
          wait_q  <= '0;
        end
        EXEC_WAIT: begin
          if (wait_last) begin
            acc_q     <= acc_d;
            pc_q      <= pc_inc;
            address_q <= pc_inc;
            read_q    <= 1'b1;
            wait_q    <= '0;
            state_q   <= FETCH_ADDR;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        EXEC: begin
          if (exec_illegal) begin
            state_q   <= HALTED;
            running_q <= 1'b0;
            fault_q   <= 1'b1;
          end else if (exec_op == OP_STP) begin
            state_q   <= HALTED;
            running_q <= 1'b0;
          end else begin
            pc_q      <= pc_d;
            address_q <= pc_d;
            read_q    <= 1'b1;
            state_q   <= FETCH_ADDR;
            if (exec_op == OP_OUT) begin
              out_valid_q <= 1'b1;
              out_data_q  <= acc_q;
            end
          end
        end
        HALTED: begin
          state_q <= HALTED;
        end
        default: begin
          state_q   <= HALTED;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign running   = running_q;
  assign fault     = fault_q;
  assign address   = address_q;
  assign read      = read_q;
  assign write     = write_q;
  assign writedata = acc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef CPU_MU0_PERF_COUNT_EN
  logic        instr_done;
  logic [31:0] cycle_count_q;
  logic [31:0] instr_count_q;

  // An instruction completes on the last cycle of a memory operand read or
  // on its single EXEC cycle (STP included, illegal opcodes excluded).
  always_comb begin
    instr_done = ((state_q == EXEC_WAIT) && wait_last) ||
                 ((state_q == EXEC) && !exec_illegal);
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      if ((state_q != HALTED) && (cycle_count_q != 32'hFFFF_FFFF))
        cycle_count_q <= cycle_count_q + 32'd1;
      if (instr_done && (instr_count_q != 32'hFFFF_FFFF))
        instr_count_q <= instr_count_q + 32'd1;
    end
  end

  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
`endif

endmodule
